// File: rtl/pcs_rx_block_sync.sv
// 64b/66b receive block synchronizer: hunts for sync-header alignment by slipping
// the gearbox, then declares and supervises block lock over 64-header windows.
module pcs_rx_block_sync #(
    parameter int DATA_WIDTH     = 32,
    parameter int SH_CNT_MAX     = 64,
    parameter int SH_INVALID_MAX = 16,
    parameter int SLIP_WAIT      = 32
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic [DATA_WIDTH-1:0] i_rx_data,
    input  logic [1:0]            i_rx_hdr,
    input  logic                  i_rx_hdr_valid,
    input  logic                  i_rx_data_valid,
    output logic                  o_rx_slip,
    output logic                  o_block_lock,
    output logic [DATA_WIDTH-1:0] o_rx_data,
    output logic [1:0]            o_rx_hdr,
    output logic                  o_rx_hdr_valid,
    output logic                  o_rx_valid
);

    localparam int WAIT_W = $clog2(SLIP_WAIT + 1);

    typedef enum logic [1:0] {
        ST_RESET_CNT,
        ST_TEST,
        ST_SLIP,
        ST_SLIP_WAIT
    } state_t;

    // A sync header is valid only when its two bits differ (01 data, 10 control).
    function automatic logic sh_valid(input logic [1:0] sh);
        return sh[1] ^ sh[0];
    endfunction

    state_t              state_q, state_d;
    logic [6:0]          sh_cnt_q, sh_cnt_d, sh_cnt_inc;
    logic [4:0]          sh_invalid_cnt_q, sh_invalid_cnt_d, sh_invalid_inc;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic                lock_q, lock_d;
    logic                slip_q, slip_d;
    logic                hdr_event;

    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic [1:0]            rx_hdr_q, rx_hdr_d;
    logic                  rx_hdr_valid_q, rx_hdr_valid_d;
    logic                  rx_valid_q, rx_valid_d;

    assign hdr_event      = i_rx_hdr_valid & i_rx_data_valid;
    assign sh_cnt_inc     = sh_cnt_q + 7'd1;
    assign sh_invalid_inc = sh_invalid_cnt_q + 5'd1;

    always_comb begin
        state_d          = state_q;
        sh_cnt_d         = sh_cnt_q;
        sh_invalid_cnt_d = sh_invalid_cnt_q;
        wait_cnt_d       = wait_cnt_q;
        lock_d           = lock_q;
        slip_d           = 1'b0;

        case (state_q)
            ST_RESET_CNT: begin
                sh_cnt_d         = '0;
                sh_invalid_cnt_d = '0;
                state_d          = ST_TEST;
            end

            ST_TEST: begin
                if (hdr_event) begin
                    sh_cnt_d = sh_cnt_inc;
                    if (sh_valid(i_rx_hdr)) begin
                        if (sh_cnt_inc == 7'(SH_CNT_MAX)) begin
                            if (sh_invalid_cnt_q == 5'd0) begin
                                lock_d = 1'b1;
                            end
                            state_d = ST_RESET_CNT;
                        end
                    end else begin
                        sh_invalid_cnt_d = sh_invalid_inc;
                        // Unlock takes priority over a window ending on the same header.
                        if (!lock_q || (sh_invalid_inc == 5'(SH_INVALID_MAX))) begin
                            lock_d  = 1'b0;
                            slip_d  = 1'b1;
                            state_d = ST_SLIP;
                        end else if (sh_cnt_inc == 7'(SH_CNT_MAX)) begin
                            state_d = ST_RESET_CNT;
                        end
                    end
                end
            end

            ST_SLIP: begin
                lock_d     = 1'b0;
                wait_cnt_d = '0;
                state_d    = ST_SLIP_WAIT;
            end

            ST_SLIP_WAIT: begin
                // The gearbox needs time to settle after a slip; pauses do not stretch this.
                if (wait_cnt_q == WAIT_W'(SLIP_WAIT - 1)) begin
                    state_d = ST_RESET_CNT;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end

            default: begin
                state_d = ST_RESET_CNT;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q          <= ST_RESET_CNT;
            sh_cnt_q         <= '0;
            sh_invalid_cnt_q <= '0;
            wait_cnt_q       <= '0;
            lock_q           <= 1'b0;
            slip_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            sh_cnt_q         <= sh_cnt_d;
            sh_invalid_cnt_q <= sh_invalid_cnt_d;
            wait_cnt_q       <= wait_cnt_d;
            lock_q           <= lock_d;
            slip_q           <= slip_d;
        end
    end

    // Output register stage: data qualified with the lock seen in the same cycle.
    always_comb begin
        rx_data_d      = rx_data_q;
        rx_hdr_d       = rx_hdr_q;
        if (i_rx_data_valid) begin
            rx_data_d = i_rx_data;
            rx_hdr_d  = i_rx_hdr;
        end
        rx_hdr_valid_d = hdr_event;
        rx_valid_d     = i_rx_data_valid & lock_q;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rx_data_q      <= '0;
            rx_hdr_q       <= 2'b00;
            rx_hdr_valid_q <= 1'b0;
            rx_valid_q     <= 1'b0;
        end else begin
            rx_data_q      <= rx_data_d;
            rx_hdr_q       <= rx_hdr_d;
            rx_hdr_valid_q <= rx_hdr_valid_d;
            rx_valid_q     <= rx_valid_d;
        end
    end

    assign o_rx_slip      = slip_q;
    assign o_block_lock   = lock_q;
    assign o_rx_data      = rx_data_q;
    assign o_rx_hdr       = rx_hdr_q;
    assign o_rx_hdr_valid = rx_hdr_valid_q;
    assign o_rx_valid     = rx_valid_q;

endmodule

// File: tb/tb_pcs_rx_block_sync.sv
// Bench for pcs_rx_block_sync: directed phases with randomized data/headers,
// compared every cycle against a window/blackout model of the lock rules.
module tb_pcs_rx_block_sync;

    localparam int DW             = 32;
    localparam int SH_CNT_MAX     = 64;
    localparam int SH_INVALID_MAX = 16;
    localparam int SLIP_WAIT      = 32;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] i_rx_data;
    logic [1:0]    i_rx_hdr;
    logic          i_rx_hdr_valid;
    logic          i_rx_data_valid;
    logic          o_rx_slip;
    logic          o_block_lock;
    logic [DW-1:0] o_rx_data;
    logic [1:0]    o_rx_hdr;
    logic          o_rx_hdr_valid;
    logic          o_rx_valid;

    pcs_rx_block_sync #(
        .DATA_WIDTH    (DW),
        .SH_CNT_MAX    (SH_CNT_MAX),
        .SH_INVALID_MAX(SH_INVALID_MAX),
        .SLIP_WAIT     (SLIP_WAIT)
    ) dut (
        .i_clk          (clk),
        .i_reset_n      (rst_n),
        .i_rx_data      (i_rx_data),
        .i_rx_hdr       (i_rx_hdr),
        .i_rx_hdr_valid (i_rx_hdr_valid),
        .i_rx_data_valid(i_rx_data_valid),
        .o_rx_slip      (o_rx_slip),
        .o_block_lock   (o_block_lock),
        .o_rx_data      (o_rx_data),
        .o_rx_hdr       (o_rx_hdr),
        .o_rx_hdr_valid (o_rx_hdr_valid),
        .o_rx_valid     (o_rx_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    // reference model: blackout countdown plus per-window header tallies
    int            m_ignore;
    int            m_cnt;
    int            m_inv;
    bit            m_lock;
    logic          e_slip, e_lock, e_hv, e_valid;
    logic [DW-1:0] e_data;
    logic [1:0]    e_hdr;

    int cyc           = 0;
    int rel_cyc       = 0;
    int n_slips       = 0;
    int last_slip_cyc = -1;
    bit lock_seen     = 0;
    int lock_lat      = -1;
    int pause_period  = 0;
    bit pause_rand    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h (failure %0d)", tag, obs, exp, n_fail);
        end
    endtask

    task automatic model_reset();
        m_ignore = 1;
        m_cnt    = 0;
        m_inv    = 0;
        m_lock   = 0;
        e_slip   = 0;
        e_lock   = 0;
        e_hv     = 0;
        e_valid  = 0;
        e_data   = '0;
        e_hdr    = 2'b00;
    endtask

    task automatic model_edge(input logic dv, input logic hv, input logic [1:0] h, input logic [DW-1:0] d);
        bit bad;
        e_valid = dv & m_lock;
        e_hv    = hv & dv;
        if (dv) begin
            e_data = d;
            e_hdr  = h;
        end
        e_slip = 0;
        if (m_ignore > 0) begin
            m_ignore--;
        end else if (dv && hv) begin
            bad = (h == 2'b00) || (h == 2'b11);
            m_cnt++;
            if (bad) m_inv++;
            if (bad && (!m_lock || m_inv == SH_INVALID_MAX)) begin
                m_lock   = 0;
                e_slip   = 1;
                m_ignore = SLIP_WAIT + 2;
                m_cnt    = 0;
                m_inv    = 0;
            end else if (m_cnt == SH_CNT_MAX) begin
                if (m_inv == 0) m_lock = 1;
                m_ignore = 1;
                m_cnt    = 0;
                m_inv    = 0;
            end
        end
        e_lock = m_lock;
    endtask

    task automatic check_outputs();
        chk("slip", o_rx_slip, e_slip);
        chk("block_lock", o_block_lock, e_lock);
        chk("rx_data", o_rx_data, e_data);
        chk("rx_hdr", o_rx_hdr, e_hdr);
        chk("rx_hdr_valid", o_rx_hdr_valid, e_hv);
        chk("rx_valid", o_rx_valid, e_valid);
        if (o_rx_slip === 1'b1) begin
            n_slips++;
            if (last_slip_cyc >= 0)
                chk("slip_gap_ok", (cyc - last_slip_cyc) >= (SLIP_WAIT + 2), 1);
            last_slip_cyc = cyc;
        end
        if (!lock_seen && o_block_lock === 1'b1) begin
            lock_seen = 1;
            lock_lat  = cyc - rel_cyc;
        end
    endtask

    task automatic step(input logic dv, input logic hv, input logic [1:0] h, input logic [DW-1:0] d);
        i_rx_data_valid = dv;
        i_rx_hdr_valid  = hv;
        i_rx_hdr        = h;
        i_rx_data       = d;
        @(posedge clk);
        model_edge(dv, hv, h, d);
        cyc++;
        #1;
        check_outputs();
    endtask

    task automatic word(input logic hv, input logic [1:0] h);
        bit do_pause;
        do_pause = (pause_period > 0 && (cyc % pause_period) == pause_period - 1) ||
                   (pause_rand && $urandom_range(9, 0) == 0);
        if (do_pause)
            step(1'b0, 1'($urandom_range(1, 0)), 2'($urandom_range(3, 0)), $urandom);
        step(1'b1, hv, h, $urandom);
    endtask

    task automatic send_block(input logic [1:0] h);
        word(1'b1, h);
        word(1'b0, 2'($urandom_range(3, 0)));
    endtask

    function automatic logic [1:0] good_hdr();
        return ($urandom_range(1, 0) == 0) ? 2'b01 : 2'b10;
    endfunction

    function automatic logic [1:0] bad_hdr();
        return ($urandom_range(1, 0) == 0) ? 2'b00 : 2'b11;
    endfunction

    // 64 blocks, n_bad invalid headers scattered; force_last puts one extra at the end
    task automatic send_window(input int n_bad, input bit force_last);
        bit flags [64];
        int span;
        int j;
        bit t;
        span = force_last ? 63 : 64;
        for (int i = 0; i < 64; i++) flags[i] = (i < n_bad);
        for (int i = span - 1; i > 0; i--) begin
            j        = $urandom_range(i, 0);
            t        = flags[i];
            flags[i] = flags[j];
            flags[j] = t;
        end
        if (force_last) flags[63] = 1;
        for (int i = 0; i < 64; i++) send_block(flags[i] ? bad_hdr() : good_hdr());
    endtask

    task automatic do_reset();
        i_rx_data_valid = 1'b0;
        i_rx_hdr_valid  = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_slip", o_rx_slip, 0);
        chk("rst_lock", o_block_lock, 0);
        chk("rst_data", o_rx_data, 0);
        chk("rst_hdr", o_rx_hdr, 0);
        chk("rst_hdr_valid", o_rx_hdr_valid, 0);
        chk("rst_valid", o_rx_valid, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        rel_cyc       = cyc;
        lock_seen     = 0;
        lock_lat      = -1;
        last_slip_cyc = -1;
    endtask

    initial begin
        int s0;
        rst_n           = 1'b0;
        i_rx_data       = '0;
        i_rx_hdr        = 2'b00;
        i_rx_hdr_valid  = 1'b0;
        i_rx_data_valid = 1'b0;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        chk("por_lock", o_block_lock, 0);
        chk("por_slip", o_rx_slip, 0);
        chk("por_data", o_rx_data, 0);
        chk("por_valid", o_rx_valid, 0);
        #2 rst_n = 1'b1;
        rel_cyc = cyc;

        // aligned cold start
        s0 = n_slips;
        repeat (65) send_block(2'b01);
        chk("cold_lock", o_block_lock, 1);
        chk("cold_latency", lock_lat, 129);
        chk("cold_no_slip", n_slips - s0, 0);

        // locked: 15 invalid in a window keeps lock
        s0 = n_slips;
        send_window(15, 1'b0);
        chk("inv15_lock_held", o_block_lock, 1);
        chk("inv15_no_slip", n_slips - s0, 0);

        // 16th invalid on the window's last header: unlock wins
        s0 = n_slips;
        send_window(15, 1'b1);
        chk("inv16_unlock", o_block_lock, 0);
        repeat (17) send_block(good_hdr());
        chk("inv16_one_slip", n_slips - s0, 1);

        // relock on 2'b10 headers only
        repeat (64) send_block(2'b10);
        chk("hdr10_lock", o_block_lock, 1);

        // reset while locked, then misaligned start with 11 x3 and 00 x1
        do_reset();
        s0 = n_slips;
        send_block(good_hdr());
        for (int k = 0; k < 3; k++) begin
            send_block(2'b11);
            repeat (17) send_block(good_hdr());
        end
        chk("misalign_3_slips", n_slips - s0, 3);
        send_block(2'b00);
        repeat (17) send_block(good_hdr());
        chk("hdr00_slip", n_slips - s0, 4);
        chk("misalign_unlocked", o_block_lock, 0);
        repeat (64) send_block(good_hdr());
        chk("misalign_lock", o_block_lock, 1);

        // reset while locked, provoke a slip, reset mid slip-wait, warm restart
        do_reset();
        s0 = n_slips;
        send_block(good_hdr());
        send_block(2'b11);
        repeat (5) send_block(good_hdr());
        chk("midwait_slip", n_slips - s0, 1);
        do_reset();
        repeat (65) send_block(2'b01);
        chk("warm_lock", o_block_lock, 1);
        chk("warm_latency", lock_lat, 129);

        // gearbox pause every 33rd cycle
        do_reset();
        pause_period = 33;
        repeat (66) send_block(good_hdr());
        chk("pause_lock", o_block_lock, 1);
        pause_period = 0;

        // random headers and pauses against the model
        pause_rand = 1;
        for (int b = 0; b < 300; b++)
            send_block(($urandom_range(19, 0) == 0) ? bad_hdr() : good_hdr());
        pause_rand = 0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pcs_rx_block_sync.md
# pcs_rx_block_sync

Receive-side 64b/66b block synchronizer for the 10G PCS. Sits directly downstream of the GTY receive gearbox and upstream of the descrambler/XGMII decoder. It tests each 2-bit sync header, pulses a gearbox slip request until header alignment is found, and asserts block lock per IEEE 802.3 clause 49. The 32-bit data path is registered and qualified with lock.

## Interface
- DATA_WIDTH, 32, GTY RX data word width. Two words form one 66b block.
- SH_CNT_MAX, 64, valid-header-opportunity window length in blocks.
- SH_INVALID_MAX, 16, invalid headers per window that drop lock.
- SLIP_WAIT, 32, minimum cycles after a slip pulse before header testing resumes.

- i_clk  in  1  RX user clock, all logic rising-edge.
- i_reset_n  in  1  Asynchronous active-low reset.
- i_rx_data  in  DATA_WIDTH  Gearbox data word.
- i_rx_hdr  in  2  Sync header. Meaningful only when i_rx_hdr_valid=1.
- i_rx_hdr_valid  in  1  High on the first word of each block.
- i_rx_data_valid  in  1  Gearbox data valid. Low on gearbox pause cycles.
- o_rx_slip  out  1  One-cycle slip request to the GTY gearbox.
- o_block_lock  out  1  Block lock status.
- o_rx_data  out  DATA_WIDTH  Registered i_rx_data.
- o_rx_hdr  out  2  Registered i_rx_hdr.
- o_rx_hdr_valid  out  1  Registered i_rx_hdr_valid & i_rx_data_valid.
- o_rx_valid  out  1  Registered i_rx_data_valid & o_block_lock.

## Operation
- Header test event: the cycle where i_rx_hdr_valid=1 and i_rx_data_valid=1. Other cycles do not touch counters.
  - Valid header: 2'b01 or 2'b10.
  - Invalid header: 2'b00 or 2'b11.
- Counters:
  - sh_cnt is 7 bits and counts test events in the current window.
  - sh_invalid_cnt is 5 bits and counts invalid headers in the current window.
  - Both counters clear on entry to TEST from RESET_CNT or SLIP_WAIT.
- FSM states: RESET_CNT, TEST, SLIP, SLIP_WAIT.
  - RESET_CNT: clears both counters, then goes to TEST next cycle.
  - TEST, valid header:
    - sh_cnt increments.
    - If the new sh_cnt equals SH_CNT_MAX: when sh_invalid_cnt==0, set o_block_lock=1. Then go to RESET_CNT.
  - TEST, invalid header:
    - sh_cnt and sh_invalid_cnt both increment.
    - If o_block_lock=0: go to SLIP immediately.
    - If o_block_lock=1 and the new sh_invalid_cnt equals SH_INVALID_MAX: clear o_block_lock and go to SLIP.
    - If o_block_lock=1 and the new sh_cnt equals SH_CNT_MAX with sh_invalid_cnt below SH_INVALID_MAX: lock is held and the FSM goes to RESET_CNT.
    - If SH_INVALID_MAX and SH_CNT_MAX are reached on the same event, unlock wins.
  - SLIP: o_rx_slip=1 for exactly one cycle, o_block_lock=0, then go to SLIP_WAIT.
  - SLIP_WAIT: a wait counter runs SLIP_WAIT cycles. Header events are ignored. Then go to RESET_CNT.
- Slip rate: o_rx_slip never pulses more than once per SLIP_WAIT+2 cycles.
- Data path: o_rx_data and o_rx_hdr update only when i_rx_data_valid=1. Otherwise they hold their value.

## Timing
- Reset values (asynchronous on i_reset_n low):
  - FSM in RESET_CNT.
  - All counters 0.
  - o_rx_slip=0, o_block_lock=0, o_rx_valid=0, o_rx_hdr_valid=0.
  - o_rx_data=0, o_rx_hdr=2'b00.
- Reset release: first test event accepted no earlier than the 2nd cycle after deassertion.
- Latency:
  - Data path: 1 cycle, input to o_rx_data/o_rx_hdr/o_rx_hdr_valid.
  - o_rx_valid uses the o_block_lock value in the same register stage as the data.
  - o_block_lock rises in the cycle after the 64th consecutive valid test event.
  - o_rx_slip asserts the cycle after the offending invalid header is sampled.
  - o_block_lock falls the cycle after the 16th invalid event. It is registered together with the transition to SLIP.
- Reset mid-operation: all state, including lock, returns to reset values within the same cycle (asynchronous). No slip pulse is emitted on reset.
- Pause cycles (i_rx_data_valid=0) stall nothing except the counters. SLIP_WAIT counts every clock.

## Test plan
- Aligned stream: 64 blocks of hdr 2'b01 -> o_rx_slip never asserts. o_block_lock rises exactly 1 cycle after the 64th header event. o_rx_valid follows one cycle later with the data.
- Misaligned start: 3 invalid headers (2'b11), then valid -> 3 slip pulses, each separated by at least 34 cycles. Lock is reached 64 valid blocks after the last slip wait.
- Locked, 15 invalid headers in a 64-block window -> lock held, no slip, counters restart. With 16 invalid headers -> o_block_lock falls and one slip pulse follows.
- Gearbox pauses: i_rx_data_valid low every 33rd cycle -> outputs hold during pauses, counters do not advance, lock is still reached after 64 test events.
- Async reset asserted while locked and mid-SLIP_WAIT -> all outputs go to 0 immediately. After release, the full lock sequence repeats with the same latency as a cold start.
- Header values 2'b00 and 2'b10 mixed: 2'b10 is counted valid, 2'b00 triggers a slip when unlocked.
